// File: rtl/xor_resp_checker.sv
// Checks a stream of (a,b,c) vectors from a 2-input XOR gate under test. It verifies c == a^b and that {a,b} steps through 0,1,2,3,0,...
// Latency: counters and flags update on the clock edge after an accept. done and pass are valid on the cycle after the final accept.
// Backpressure: in_ready is high only during a run. Vectors offered in IDLE or DONE are not accepted.
module xor_resp_checker #(
  parameter int NUM_VEC = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] seq_err_cnt,
  output logic [CNT_W-1:0] first_err_idx,
  output logic             first_err_vld
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VEC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [1:0] state;
  logic [1:0] exp_idx;
  logic       accept;
  logic       mismatch;
  logic       seq_bad;

  assign accept   = (state == S_RUN) && in_valid;
  assign mismatch = (c != (a ^ b));
  assign seq_bad  = ({a, b} != exp_idx);

  // Status outputs are decoded from the state. pass is forced low outside DONE.
  assign in_ready = (state == S_RUN);
  assign busy     = (state == S_RUN);
  assign done     = (state == S_DONE);
  assign pass     = (state == S_DONE) && (err_cnt == '0) && (seq_err_cnt == '0);

  // Run control. Vector scoring happens here, and counters freeze outside RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      exp_idx       <= 2'd0;
      vec_cnt       <= '0;
      err_cnt       <= '0;
      seq_err_cnt   <= '0;
      first_err_idx <= '0;
      first_err_vld <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state         <= S_RUN;
            exp_idx       <= 2'd0;
            vec_cnt       <= '0;
            err_cnt       <= '0;
            seq_err_cnt   <= '0;
            first_err_idx <= '0;
            first_err_vld <= 1'b0;
          end
        end
        S_RUN: begin
          if (accept) begin
            vec_cnt <= vec_cnt + CNT_ONE;
            exp_idx <= exp_idx + 2'd1;
            if (mismatch) begin
              if (err_cnt != CNT_MAX) err_cnt <= err_cnt + CNT_ONE;
              // Only the first c mismatch of the run records its index.
              if (!first_err_vld) begin
                first_err_idx <= vec_cnt;
                first_err_vld <= 1'b1;
              end
            end
            if (seq_bad && (seq_err_cnt != CNT_MAX)) begin
              seq_err_cnt <= seq_err_cnt + CNT_ONE;
            end
            if (vec_cnt == LAST_IDX) state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
